// File: rtl/spi_master_param.sv
// Parametrised full-duplex SPI master: configurable width, SCLK divider, CPOL/CPHA,
// bit order and minimum CS-high gap between frames.
module spi_master_param #(
   parameter int DATA_W    = 12,
   parameter int CLK_DIV   = 10,
   parameter bit CPOL      = 1'b0,
   parameter bit CPHA      = 1'b0,
   parameter bit MSB_FIRST = 1'b1,
   parameter int CS_GAP    = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              newd,
   input  logic [DATA_W-1:0] din,
   input  logic              miso,
   output logic              cs,
   output logic              sclk,
   output logic              mosi,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] dout
);

   localparam int CNT_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int EDGE_W  = $clog2(2 * DATA_W + 1);

   typedef enum logic [1:0] {IDLE, XFER, TRAIL, GAP} state_t;

   state_t              state;
   logic [CNT_W-1:0]    cnt;
   logic [EDGE_W-1:0]   edges;
   logic [DATA_W-1:0]   tx_sr;
   logic [DATA_W-1:0]   rx_sr;

   function automatic logic first_bit(input logic [DATA_W-1:0] w);
      return MSB_FIRST ? w[DATA_W-1] : w[0];
   endfunction

   function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w);
      return MSB_FIRST ? {w[DATA_W-2:0], 1'b0} : {1'b0, w[DATA_W-1:1]};
   endfunction

   function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] w, input logic b);
      return MSB_FIRST ? {w[DATA_W-2:0], b} : {b, w[DATA_W-1:1]};
   endfunction

   // Shift registers carry data only; they are reloaded on every accepted start.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cs    <= 1'b1;
         sclk  <= CPOL;
         mosi  <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
         dout  <= '0;
         cnt   <= '0;
         edges <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               cs   <= 1'b1;
               sclk <= CPOL;
               mosi <= 1'b0;
               if (newd) begin
                  tx_sr <= din;
                  rx_sr <= '0;
                  cs    <= 1'b0;
                  busy  <= 1'b1;
                  cnt   <= '0;
                  edges <= '0;
                  state <= XFER;
                  if (!CPHA) mosi <= first_bit(din);
               end
            end
            XFER: begin
               if (cnt == CNT_W'(CLK_DIV - 1)) begin
                  cnt   <= '0;
                  sclk  <= ~sclk;
                  edges <= edges + EDGE_W'(1);
                  // Even edge count before the toggle means this is a leading edge.
                  if (!edges[0]) begin
                     if (CPHA) begin
                        mosi  <= first_bit(tx_sr);
                        tx_sr <= shift_out(tx_sr);
                     end else begin
                        rx_sr <= shift_in(rx_sr, miso);
                     end
                  end else begin
                     if (CPHA) begin
                        rx_sr <= shift_in(rx_sr, miso);
                     end else if (edges != EDGE_W'(2 * DATA_W - 1)) begin
                        tx_sr <= shift_out(tx_sr);
                        mosi  <= first_bit(shift_out(tx_sr));
                     end
                  end
                  if (edges == EDGE_W'(2 * DATA_W - 1)) begin
                     sclk  <= CPOL;
                     state <= TRAIL;
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            TRAIL: begin
               if (cnt == CNT_W'(CLK_DIV - 1)) begin
                  cnt   <= '0;
                  cs    <= 1'b1;
                  mosi  <= 1'b0;
                  dout  <= rx_sr;
                  done  <= 1'b1;
                  state <= GAP;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            GAP: begin
               if (cnt == CNT_W'(CS_GAP - 1)) begin
                  cnt   <= '0;
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_master_param.sv
// Scoreboard bench for spi_master_param: three configurations (mode 0 MSB-first loopback,
// mode 3 against a slave model, LSB-first loopback) with random and directed frames.
module tb_spi_master_param;

   localparam int WA = 12, DA = 4, GA = 2;
   localparam int WB = 8,  DB = 3, GB = 2;
   localparam int WC = 8,  DC = 2, GC = 3;

   typedef struct packed {
      logic [WB-1:0] d;
      logic [WB-1:0] s;
   } expb_t;

   logic clk, rst;

   logic          newd_a, miso_a, cs_a, sclk_a, mosi_a, busy_a, done_a;
   logic [WA-1:0] din_a, dout_a;
   logic          newd_b, miso_b, cs_b, sclk_b, mosi_b, busy_b, done_b;
   logic [WB-1:0] din_b, dout_b;
   logic          newd_c, miso_c, cs_c, sclk_c, mosi_c, busy_c, done_c;
   logic [WC-1:0] din_c, dout_c;

   int            checks, failures;
   int unsigned   cyc;
   logic [WA-1:0] qa[$];
   expb_t         qb[$];
   logic [WC-1:0] qc[$];
   logic [WB-1:0] slave_tx;
   int            edges_a, idle_bad, mosi_bad;

   assign miso_a = mosi_a;
   assign miso_c = mosi_c;

   spi_master_param #(.DATA_W(WA), .CLK_DIV(DA), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b1), .CS_GAP(GA)) dut_a (
      .clk(clk), .rst(rst), .newd(newd_a), .din(din_a), .miso(miso_a), .cs(cs_a),
      .sclk(sclk_a), .mosi(mosi_a), .busy(busy_a), .done(done_a), .dout(dout_a));

   spi_master_param #(.DATA_W(WB), .CLK_DIV(DB), .CPOL(1'b1), .CPHA(1'b1), .MSB_FIRST(1'b1), .CS_GAP(GB)) dut_b (
      .clk(clk), .rst(rst), .newd(newd_b), .din(din_b), .miso(miso_b), .cs(cs_b),
      .sclk(sclk_b), .mosi(mosi_b), .busy(busy_b), .done(done_b), .dout(dout_b));

   spi_master_param #(.DATA_W(WC), .CLK_DIV(DC), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b0), .CS_GAP(GC)) dut_c (
      .clk(clk), .rst(rst), .newd(newd_c), .din(din_c), .miso(miso_c), .cs(cs_c),
      .sclk(sclk_c), .mosi(mosi_c), .busy(busy_c), .done(done_c), .dout(dout_c));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      cyc = 0;
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic logic busy_of(input int which);
      case (which)
         0:       return busy_a;
         1:       return busy_b;
         default: return busy_c;
      endcase
   endfunction

   task automatic wait_idle(input int which);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (busy_of(which) !== 1'b0 && n < 500);
      check($sformatf("idle_wait_%0d", which), {31'b0, busy_of(which)}, 0);
   endtask

   task automatic run_a(input logic [WA-1:0] d);
      @(negedge clk);
      din_a = d; newd_a = 1'b1; qa.push_back(d);
      @(negedge clk);
      newd_a = 1'b0; din_a = WA'($urandom);
      wait_idle(0);
   endtask

   task automatic run_b(input logic [WB-1:0] d, input logic [WB-1:0] s);
      expb_t e;
      e.d = d; e.s = s;
      @(negedge clk);
      slave_tx = s; din_b = d; newd_b = 1'b1; qb.push_back(e);
      @(negedge clk);
      newd_b = 1'b0; din_b = WB'($urandom);
      wait_idle(1);
   endtask

   task automatic run_c(input logic [WC-1:0] d);
      @(negedge clk);
      din_c = d; newd_c = 1'b1; qc.push_back(d);
      @(negedge clk);
      newd_c = 1'b0; din_c = WC'($urandom);
      wait_idle(2);
   endtask

   // Monitor A: reassembles the wire word from mode-0 sample edges, counts SCLK edges, pops on done.
   initial begin : mon_a
      logic pcs, psclk;
      int n;
      logic [WA-1:0] wire_w, e;
      pcs = 1'b1; psclk = 1'b0; n = 0; wire_w = '0; edges_a = 0;
      forever begin
         @(negedge clk);
         if (cs_a === 1'b0 && pcs === 1'b1) begin edges_a = 0; wire_w = '0; n = 0; end
         if (cs_a === 1'b0 && sclk_a !== psclk) begin
            edges_a++;
            if (sclk_a === 1'b1 && n < WA) begin wire_w[WA-1-n] = mosi_a; n++; end
         end
         if (cs_a === 1'b1 && sclk_a !== 1'b0) idle_bad++;
         if (done_a === 1'b1) begin
            if (qa.size() == 0) check("a_unexpected_done", 1, 0);
            else begin
               e = qa.pop_front();
               check("a_dout", dout_a, e);
               check("a_wire", wire_w, e);
               check("a_edges", edges_a, 2 * WA);
            end
         end
         pcs = cs_a; psclk = sclk_a;
      end
   end

   // Monitor B plus mode-3 slave: drives miso on falling (leading) edges, samples mosi on rising edges.
   initial begin : mon_b
      logic pcs, psclk, pmosi;
      int sbit, edges;
      logic [WB-1:0] srx;
      expb_t e;
      pcs = 1'b1; psclk = 1'b1; pmosi = 1'b0; sbit = 0; edges = 0; srx = '0; miso_b = 1'b0;
      forever begin
         @(negedge clk);
         if (cs_b === 1'b0 && pcs === 1'b1) begin sbit = 0; srx = '0; edges = 0; end
         if (cs_b === 1'b0 && sclk_b !== psclk) begin
            edges++;
            if (sclk_b === 1'b0) begin
               if (sbit < WB) miso_b = slave_tx[WB-1-sbit];
            end else begin
               if (mosi_b !== pmosi) mosi_bad++;
               srx = {srx[WB-2:0], mosi_b};
               sbit++;
            end
         end else if (cs_b === 1'b0 && pcs === 1'b0 && mosi_b !== pmosi) begin
            mosi_bad++;
         end
         if (cs_b === 1'b1 && sclk_b !== 1'b1) idle_bad++;
         if (done_b === 1'b1) begin
            if (qb.size() == 0) check("b_unexpected_done", 1, 0);
            else begin
               e = qb.pop_front();
               check("b_dout", dout_b, e.s);
               check("b_slave_rx", srx, e.d);
               check("b_edges", edges, 2 * WB);
            end
         end
         pcs = cs_b; psclk = sclk_b; pmosi = mosi_b;
      end
   end

   // Monitor C: LSB-first, so the k-th bit on the wire is din[k].
   initial begin : mon_c
      logic pcs, psclk;
      int n, edges;
      logic [WC-1:0] wire_w, e;
      pcs = 1'b1; psclk = 1'b0; n = 0; edges = 0; wire_w = '0;
      forever begin
         @(negedge clk);
         if (cs_c === 1'b0 && pcs === 1'b1) begin edges = 0; wire_w = '0; n = 0; end
         if (cs_c === 1'b0 && sclk_c !== psclk) begin
            edges++;
            if (sclk_c === 1'b1 && n < WC) begin wire_w[n] = mosi_c; n++; end
         end
         if (cs_c === 1'b1 && sclk_c !== 1'b0) idle_bad++;
         if (done_c === 1'b1) begin
            if (qc.size() == 0) check("c_unexpected_done", 1, 0);
            else begin
               e = qc.pop_front();
               check("c_dout", dout_c, e);
               check("c_wire", wire_w, e);
               check("c_edges", edges, 2 * WC);
            end
         end
         pcs = cs_c; psclk = sclk_c;
      end
   end

   initial begin : stim
      int unsigned t0;
      int n, gap;
      logic [WA-1:0] d;
      checks = 0; failures = 0; idle_bad = 0; mosi_bad = 0;
      rst = 1'b1; slave_tx = '0;
      newd_a = 1'b0; newd_b = 1'b0; newd_c = 1'b0;
      din_a = '0; din_b = '0; din_c = '0;
      repeat (3) @(negedge clk);
      check("rst_cs_a", cs_a, 1);     check("rst_sclk_a", sclk_a, 0);
      check("rst_mosi_a", mosi_a, 0); check("rst_busy_a", busy_a, 0);
      check("rst_done_a", done_a, 0); check("rst_dout_a", dout_a, 0);
      check("rst_cs_b", cs_b, 1);     check("rst_sclk_b", sclk_b, 1);
      check("rst_busy_b", busy_b, 0); check("rst_dout_b", dout_b, 0);
      check("rst_sclk_c", sclk_c, 0); check("rst_mosi_c", mosi_c, 0);
      rst = 1'b0;
      @(negedge clk);

      // Directed mode-0 timing frame, cycle numbers relative to the accepting edge T.
      @(negedge clk);
      din_a = 12'hA5C; newd_a = 1'b1; qa.push_back(12'hA5C);
      @(negedge clk);
      t0 = cyc; newd_a = 1'b0;
      check("a_cs_low_T1", cs_a, 0);
      check("a_busy_T1", busy_a, 1);
      n = 0;
      while (done_a !== 1'b1 && n < 300) begin @(negedge clk); n++; end
      check("a_done_cycle", cyc - t0 + 1, 101);
      check("a_cs_rise_with_done", cs_a, 1);
      while (busy_a !== 1'b0 && n < 300) begin @(negedge clk); n++; end
      check("a_busy_low_cycle", cyc - t0 + 1, 103);

      run_b(8'hF0, 8'h3C);
      run_c(8'h01);

      for (int i = 0; i < 5; i++) begin
         run_a(WA'($urandom));
         run_b(WB'($urandom), WB'($urandom));
         run_c(WC'($urandom));
      end

      // Start request while busy must be ignored.
      d = 12'h400 | WA'($urandom_range(0, 12'h3FF));
      @(negedge clk);
      din_a = d; newd_a = 1'b1; qa.push_back(d);
      @(negedge clk);
      newd_a = 1'b0;
      repeat (30) @(negedge clk);
      din_a = 12'hFFF; newd_a = 1'b1;
      @(negedge clk);
      newd_a = 1'b0;
      wait_idle(0);
      repeat (10) @(negedge clk);
      check("a_repulse_queue", qa.size(), 0);

      // Reset in the middle of a frame.
      @(negedge clk);
      din_a = 12'h5A3; newd_a = 1'b1; qa.push_back(12'h5A3);
      @(negedge clk);
      newd_a = 1'b0;
      repeat (2) @(negedge clk);
      n = 0;
      while (edges_a < 10 && n < 200) begin @(negedge clk); n++; end
      check("a_edges_before_rst", edges_a, 10);
      rst = 1'b1;
      @(negedge clk);
      check("a_midrst_cs", cs_a, 1);     check("a_midrst_sclk", sclk_a, 0);
      check("a_midrst_mosi", mosi_a, 0); check("a_midrst_busy", busy_a, 0);
      check("a_midrst_done", done_a, 0); check("a_midrst_dout", dout_a, 0);
      qa.delete();
      rst = 1'b0;
      repeat (3 * 2 * WA) @(negedge clk);
      run_a(WA'($urandom));

      // newd held high: two back-to-back frames.
      @(negedge clk);
      din_a = 12'h123; newd_a = 1'b1; qa.push_back(12'h123); qa.push_back(12'h456);
      @(negedge clk);
      din_a = 12'h456;
      n = 0;
      while (done_a !== 1'b1 && n < 300) begin @(negedge clk); n++; end
      gap = 0;
      while (cs_a === 1'b1 && n < 300) begin gap++; @(negedge clk); n++; end
      newd_a = 1'b0;
      check("a_cs_gap", gap, GA + 1);
      wait_idle(0);

      repeat (20) @(negedge clk);
      check("qa_empty", qa.size(), 0);
      check("qb_empty", qb.size(), 0);
      check("qc_empty", qc.size(), 0);
      check("sclk_idle_level", idle_bad, 0);
      check("b_mosi_on_leading_only", mosi_bad, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
